alu_seq: RTL and testbench

//  Parametrised, handshaked ALU: the 16-op set with start/busy/done control and configurable datapath width.

---
 rtl/alu_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked 16-op ALU with start/busy/done control.
// Single-cycle ops finish one edge after accept. MUL (shift-add) and DIV
// (restoring) run one iteration per cycle and finish WIDTH edges after accept.
// DIV by zero finishes in one edge, returns all ones and sets div_by_zero.
module alu_seq #(
    parameter int WIDTH = 72,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_LSL  = 4'd4;
    localparam logic [3:0] OP_LSR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SUBI = 4'd7;
    localparam logic [3:0] OP_ANDI = 4'd8;
    localparam logic [3:0] OP_LAND = 4'd9;
    localparam logic [3:0] OP_LOR  = 4'd10;
    localparam logic [3:0] OP_XOR  = 4'd11;
    localparam logic [3:0] OP_EQ   = 4'd12;
    localparam logic [3:0] OP_NE   = 4'd13;
    localparam logic [3:0] OP_LT   = 4'd14;
    localparam logic [3:0] OP_GT   = 4'd15;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [3:0]       op_r, op_nxt_s;
    logic [WIDTH-1:0] a_r, a_nxt_s;      // MUL: multiplicand, DIV: dividend/quotient
    logic [WIDTH-1:0] b_r, b_nxt_s;      // MUL: multiplier, DIV: divisor
    logic [WIDTH-1:0] acc_r, acc_nxt_s;  // MUL: partial product, DIV: remainder
    logic [SHW-1:0]   cnt_r, cnt_nxt_s;
    logic             iter_r, iter_nxt_s;
    logic [WIDTH-1:0] c_r, c_nxt_s;
    logic             done_r, done_nxt_s;
    logic             dbz_r, dbz_nxt_s;

    logic             accept_s;
    logic             fin_s;
    logic [WIDTH-1:0] mul_acc_s;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH:0]   diff_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] quo_nxt_s;
    logic [WIDTH-1:0] single_res_s;

    // Zero-extend a boolean to the datapath width.
    function automatic logic [WIDTH-1:0] to_w(input logic f_bit);
        return {{(WIDTH-1){1'b0}}, f_bit};
    endfunction

    // Result of every single-cycle opcode from latched operands.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       f_op,
        input logic [WIDTH-1:0] f_a,
        input logic [WIDTH-1:0] f_b
    );
        logic signed [IMM_W-1:0] imm;
        logic [WIDTH-1:0]        sext;
        logic [SHW-1:0]          shamt;
        logic                    sh_over;
        logic [WIDTH-1:0]        res;
        imm     = $signed(f_b[IMM_W-1:0]);
        sext    = WIDTH'(imm);
        shamt   = f_b[SHW-1:0];
        sh_over = (32'(shamt) >= 32'(WIDTH));
        case (f_op)
            OP_ADD:  res = f_a + f_b;
            OP_SUB:  res = f_a - f_b;
            OP_LSL:  res = sh_over ? ZERO_W : (f_a << shamt);
            OP_LSR:  res = sh_over ? ZERO_W : (f_a >> shamt);
            OP_ADDI: res = f_a + sext;
            OP_SUBI: res = f_a - sext;
            OP_ANDI: res = f_a & sext;
            OP_LAND: res = to_w((f_a != ZERO_W) && (f_b != ZERO_W));
            OP_LOR:  res = to_w((f_a != ZERO_W) || (f_b != ZERO_W));
            OP_XOR:  res = f_a ^ f_b;
            OP_EQ:   res = to_w(f_a == f_b);
            OP_NE:   res = to_w(f_a != f_b);
            OP_LT:   res = to_w(f_a < f_b);
            OP_GT:   res = to_w(f_a > f_b);
            default: res = ZERO_W;
        endcase
        return res;
    endfunction

    assign accept_s     = start && (state_r == S_IDLE);
    assign mul_acc_s    = acc_r + (b_r[0] ? a_r : ZERO_W);
    assign rem_shift_s  = {acc_r, a_r[WIDTH-1]};
    assign diff_s       = rem_shift_s - {1'b0, b_r};
    assign div_ge_s     = ~diff_s[WIDTH];
    assign quo_nxt_s    = {a_r[WIDTH-2:0], div_ge_s};
    assign single_res_s = alu_single(op_r, a_r, b_r);

    assign C           = c_r;
    assign busy        = (state_r == S_EXEC);
    assign done        = done_r;
    assign div_by_zero = dbz_r;

    // Detect the cycle in which the operation in flight writes its result.
    always_comb begin
        fin_s = 1'b0;
        if (state_r == S_EXEC) begin
            if (iter_r) begin
                fin_s = (cnt_r == CNT_LAST);
            end else begin
                fin_s = 1'b1;
            end
        end else begin
            fin_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> IDLE on completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_EXEC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_EXEC: begin
                if (fin_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_EXEC;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Output and datapath next values: operand latch, iteration step, result write.
    always_comb begin
        op_nxt_s   = op_r;
        a_nxt_s    = a_r;
        b_nxt_s    = b_r;
        acc_nxt_s  = acc_r;
        cnt_nxt_s  = cnt_r;
        iter_nxt_s = iter_r;
        c_nxt_s    = c_r;
        done_nxt_s = 1'b0;
        dbz_nxt_s  = dbz_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    op_nxt_s   = op;
                    a_nxt_s    = A;
                    b_nxt_s    = B;
                    acc_nxt_s  = ZERO_W;
                    cnt_nxt_s  = {SHW{1'b0}};
                    iter_nxt_s = (op == OP_MUL) || ((op == OP_DIV) && (B != ZERO_W));
                    dbz_nxt_s  = 1'b0;
                end else begin
                    done_nxt_s = 1'b0;
                end
            end
            S_EXEC: begin
                if (iter_r) begin
                    cnt_nxt_s = cnt_r + {{(SHW-1){1'b0}}, 1'b1};
                    if (op_r == OP_MUL) begin
                        acc_nxt_s = mul_acc_s;
                        a_nxt_s   = a_r << 1;
                        b_nxt_s   = b_r >> 1;
                        c_nxt_s   = fin_s ? mul_acc_s : c_r;
                    end else begin
                        acc_nxt_s = div_ge_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
                        a_nxt_s   = quo_nxt_s;
                        c_nxt_s   = fin_s ? quo_nxt_s : c_r;
                    end
                    done_nxt_s = fin_s;
                end else begin
                    done_nxt_s = 1'b1;
                    if (op_r == OP_DIV) begin
                        c_nxt_s   = ONES_W;
                        dbz_nxt_s = 1'b1;
                    end else begin
                        c_nxt_s = single_res_s;
                    end
                end
            end
            default: begin
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any op without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r   <= 4'd0;
            a_r    <= ZERO_W;
            b_r    <= ZERO_W;
            acc_r  <= ZERO_W;
            cnt_r  <= {SHW{1'b0}};
            iter_r <= 1'b0;
            c_r    <= ZERO_W;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            op_r   <= op_nxt_s;
            a_r    <= a_nxt_s;
            b_r    <= b_nxt_s;
            acc_r  <= acc_nxt_s;
            cnt_r  <= cnt_nxt_s;
            iter_r <= iter_nxt_s;
            c_r    <= c_nxt_s;
            done_r <= done_nxt_s;
            dbz_r  <= dbz_nxt_s;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq with hand-written multi-cycle sequences.
module tb_alu_seq;

    localparam int W = 72;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [3:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] c_o;
    logic         busy_o;
    logic         done_o;
    logic         dbz_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k_cyc = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        int           lat;
        logic         dbz;
    } vec_t;

    vec_t vecs[$];

    alu_seq #(.WIDTH(W), .IMM_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_i),
        .op          (op_i),
        .A           (a_i),
        .B           (b_i),
        .C           (c_o),
        .busy        (busy_o),
        .done        (done_o),
        .div_by_zero (dbz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input int lat, input logic dbz);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.c = c; v.lat = lat; v.dbz = dbz;
        vecs.push_back(v);
    endtask

    // Drive one request, accepted at the next rising edge; scramble inputs afterwards.
    task automatic accept(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start_i = 1'b1; op_i = o; a_i = a; b_i = b;
        @(posedge clk);
        #1;
        k_cyc = cyc;
        start_i = 1'b0; op_i = ~o; a_i = ~a; b_i = ~b;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = cyc - k_cyc;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] c, input int lat,
                          input logic dbz);
        int got_lat;
        accept(o, a, b);
        chk({name, " busy"}, W'(busy_o), W'(1));
        wait_done(got_lat);
        chk({name, " latency"}, W'(got_lat), W'(lat));
        chk({name, " C"}, c_o, c);
        chk({name, " div_by_zero"}, W'(dbz_o), W'(dbz));
        @(posedge clk);
        #1;
        chk({name, " done pulse width"}, W'(done_o), W'(0));
        chk({name, " C hold"}, c_o, c);
    endtask

    initial begin
        int lat;
        logic seen;

        rst_n = 1'b0; start_i = 1'b0; op_i = 4'd0; a_i = '0; b_i = '0;

        // Vector table: op, A, B, expected C, latency, expected div_by_zero.
        add(4'd0,  72'd10, 72'd15, 72'd25, 1, 1'b0);
        add(4'd1,  72'd20, 72'd5,  72'd15, 1, 1'b0);
        add(4'd1,  72'd0,  72'd1,  ONES,   1, 1'b0);
        add(4'd0,  ONES,   72'd1,  72'd0,  1, 1'b0);
        add(4'd2,  72'd6,  72'd7,  72'd42, W, 1'b0);
        add(4'd2,  ONES,   72'd2,  72'hFF_FFFF_FFFF_FFFF_FFFE, W, 1'b0);
        add(4'd2,  72'h1_0000_0001, 72'h1_0000_0001, 72'h1_0000_0002_0000_0001, W, 1'b0);
        add(4'd3,  72'd100, 72'd5, 72'd20, W, 1'b0);
        add(4'd3,  72'd7,  72'd10, 72'd0,  W, 1'b0);
        add(4'd3,  ONES,   72'd3,  72'h55_5555_5555_5555_5555, W, 1'b0);
        add(4'd3,  72'd100, 72'd0, ONES,   1, 1'b1);
        add(4'd0,  72'd1,  72'd1,  72'd2,  1, 1'b0);
        add(4'd4,  72'd1,  72'd2,  72'd4,  1, 1'b0);
        add(4'd5,  72'd16, 72'd1,  72'd8,  1, 1'b0);
        add(4'd4,  72'd1,  72'd100, 72'd0, 1, 1'b0);
        add(4'd4,  72'd1,  72'd71, 72'h80_0000_0000_0000_0000, 1, 1'b0);
        add(4'd5,  72'h80_0000_0000_0000_0000, 72'd72, 72'd0, 1, 1'b0);
        add(4'd4,  72'd1,  72'd130, 72'd4, 1, 1'b0);
        add(4'd6,  72'd100, 72'hFFFF, 72'd99, 1, 1'b0);
        add(4'd7,  72'd100, 72'hFFFF, 72'd101, 1, 1'b0);
        add(4'd6,  72'd100, 72'h1_0005, 72'd105, 1, 1'b0);
        add(4'd8,  72'd15, 72'd10, 72'd10, 1, 1'b0);
        add(4'd8,  ONES,   72'h8000, 72'hFF_FFFF_FFFF_FFFF_8000, 1, 1'b0);
        add(4'd9,  72'd5,  72'd0,  72'd0,  1, 1'b0);
        add(4'd9,  72'd5,  72'd3,  72'd1,  1, 1'b0);
        add(4'd10, 72'd0,  72'd0,  72'd0,  1, 1'b0);
        add(4'd10, 72'd0,  72'd9,  72'd1,  1, 1'b0);
        add(4'd11, 72'hF0, 72'hFF, 72'h0F, 1, 1'b0);
        add(4'd12, 72'd50, 72'd50, 72'd1,  1, 1'b0);
        add(4'd13, 72'd50, 72'd50, 72'd0,  1, 1'b0);
        add(4'd14, 72'd30, 72'd40, 72'd1,  1, 1'b0);
        add(4'd14, 72'd40, 72'd30, 72'd0,  1, 1'b0);
        add(4'd15, 72'd70, 72'd60, 72'd1,  1, 1'b0);
        add(4'd15, 72'd60, 72'd60, 72'd0,  1, 1'b0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset C", c_o, 72'd0);
        chk("reset busy", W'(busy_o), W'(0));
        chk("reset done", W'(done_o), W'(0));
        chk("reset div_by_zero", W'(dbz_o), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d op%0d", i, vecs[i].op), vecs[i].op, vecs[i].a,
                   vecs[i].b, vecs[i].c, vecs[i].lat, vecs[i].dbz);
        end

        // MUL with start pulses while busy: ignored, result unchanged, nothing queued.
        accept(4'd2, 72'd6, 72'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start_i = 1'b1; op_i = 4'd0; a_i = 72'd1; b_i = 72'd1;
        repeat (3) @(negedge clk);
        start_i = 1'b0;
        wait_done(lat);
        chk("mul busy-start latency", W'(lat), W'(W));
        chk("mul busy-start C", c_o, 72'd42);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done_o || busy_o) seen = 1'b1;
        end
        chk("mul busy-start nothing queued", W'(seen), W'(0));

        // start raised in the done cycle is accepted on the following edge.
        accept(4'd0, 72'd10, 72'd15);
        wait_done(lat);
        chk("b2b first C", c_o, 72'd25);
        start_i = 1'b1; op_i = 4'd0; a_i = 72'd3; b_i = 72'd4;
        @(posedge clk);
        #1;
        k_cyc = cyc;
        start_i = 1'b0; a_i = 72'd0; b_i = 72'd0;
        chk("b2b second busy", W'(busy_o), W'(1));
        wait_done(lat);
        chk("b2b second latency", W'(lat), W'(1));
        chk("b2b second C", c_o, 72'd7);

        // Reset mid-DIV: no done, C back to 0, then a fresh op runs normally.
        accept(4'd3, 72'd100, 72'd5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid-div reset C", c_o, 72'd0);
        chk("mid-div reset busy", W'(busy_o), W'(0));
        chk("mid-div reset done", W'(done_o), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (done_o) seen = 1'b1;
        end
        chk("mid-div reset no done", W'(seen), W'(0));
        chk("mid-div reset C kept", c_o, 72'd0);
        run_op("after reset ADD", 4'd0, 72'd10, 72'd15, 72'd25, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
